// File: rtl/scan_driver14_pkg.sv
// Shared types and constants for the scan_driver14 demux front end.
package scan14_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int   NUM_CH     = 4;
  localparam logic C_INACTIVE = 1'b1;

  typedef logic [1:0] ch_t;

endpackage

// File: rtl/scan_driver14_if.sv
// Frame handshake and demux drive bundle for scan_driver14.
interface scan_driver14_if;
  logic [3:0] iData;
  logic       iValid;
  logic       oReady;
  logic       oC;
  logic       oS1;
  logic       oS0;
  logic       oBusy;
  logic       oDone;

  modport slave (
    input  iData, iValid,
    output oReady, oC, oS1, oS0, oBusy, oDone
  );

  modport master (
    output iData, iValid,
    input  oReady, oC, oS1, oS0, oBusy, oDone
  );
endinterface

// File: rtl/scan_driver14_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled; term_o flags the last count.
module dwell_timer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/scan_driver14.sv
// Scans a latched 4-bit strobe frame onto an active-low 1-to-4 demux (iC/iS1/iS0).
// Define SCAN_BLANK_EN to insert a one-cycle blank (oC high) between channels.
module scan_driver14
  import scan14_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic            iClk,
  input  logic            iRst_n,
  scan_driver14_if.slave  bus
);

  localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);

  state_t     state_q, state_d;
  ch_t        ch_q, ch_d;
  logic [3:0] frame_q, frame_d;
  logic       c_q, c_d;
  ch_t        sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tmr_clr, tmr_en, tmr_term;

  dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_timer (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_o (tmr_term)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          frame_d = bus.iData;
          ch_d    = '0;
          tmr_clr = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_term) begin
          tmr_clr = 1'b1;
          if (ch_q == LAST_CH) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ch_d = ch_q + 2'd1;
`ifdef SCAN_BLANK_EN
            state_d = BLANK;
`endif
          end
        end
      end
      BLANK:   state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each channel appears the cycle after its decision.
  always_comb begin
    c_d    = C_INACTIVE;
    sel_d  = sel_q;
    busy_d = (state_d != IDLE);
    if (state_d == DRIVE) begin
      c_d   = ~frame_d[ch_d];
      sel_d = ch_d;
    end else if (state_d == BLANK) begin
      sel_d = ch_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      frame_q <= '0;
      c_q     <= C_INACTIVE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      c_q     <= c_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.oReady = (state_q == IDLE);
  assign bus.oC     = c_q;
  assign bus.oS1    = sel_q[1];
  assign bus.oS0    = sel_q[0];
  assign bus.oBusy  = busy_q;
  assign bus.oDone  = done_q;

endmodule

// File: tb/tb_scan_driver14.sv
// Directed bench for scan_driver14: DWELL-4 (DWELL-2 with SCAN_BLANK_EN) and DWELL-1 instances.
module tb_scan_driver14;

`ifdef SCAN_BLANK_EN
  localparam int DA = 2;
`else
  localparam int DA = 4;
`endif
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scan_driver14_if ifa();
  scan_driver14_if ifb();

  scan_driver14 #(.DWELL(DA), .CNT_W(8)) dut_a (.iClk(clk), .iRst_n(rst_n), .bus(ifa));
  scan_driver14 #(.DWELL(DB), .CNT_W(8)) dut_b (.iClk(clk), .iRst_n(rst_n), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  // Packed observation: {oC, oS1, oS0, oBusy, oDone, oReady}
  localparam logic [5:0] IDLE_RST = 6'b1_00_001;

  function automatic int flen(int d);
`ifdef SCAN_BLANK_EN
    return 4 * d + 3;
`else
    return 4 * d;
`endif
  endfunction

  // Expected outputs k cycles after the accepting edge (k=1 is the first channel-0 cycle).
  function automatic logic [5:0] expv(logic [3:0] f, int d, int k);
    int per, ch, j;
`ifdef SCAN_BLANK_EN
    per = d + 1;
`else
    per = d;
`endif
    if (k >= 1 && k <= flen(d)) begin
      ch = (k - 1) / per;
      j  = (k - 1) % per;
      if (j < d) return {~f[ch], 2'(ch), 3'b100};
      else       return {1'b1, 2'(ch + 1), 3'b100};
    end
    else if (k == flen(d) + 1) return 6'b1_11_011;
    else                       return 6'b1_11_001;
  endfunction

  function automatic logic [5:0] got(int u);
    if (u == 0) return {ifa.oC, ifa.oS1, ifa.oS0, ifa.oBusy, ifa.oDone, ifa.oReady};
    else        return {ifb.oC, ifb.oS1, ifb.oS0, ifb.oBusy, ifb.oDone, ifb.oReady};
  endfunction

  task automatic drive(int u, logic v, logic [3:0] d);
    if (u == 0) begin ifa.iValid = v; ifa.iData = d; end
    else        begin ifb.iValid = v; ifb.iData = d; end
  endtask

  task automatic check(string nm, logic [5:0] act, logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {C,S1,S0,Busy,Done,Ready}=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [5:0] e;
  } vec_t;

  vec_t tbl[$];

  // Entry i holds the inputs applied before edge i+1 and the outputs expected after it.
  task automatic build(int d, logic [3:0] f, int pulse_k, logic [3:0] pulse_d);
    tbl.delete();
    tbl.push_back('{1'b1, f, expv(f, d, 1)});
    for (int k = 2; k <= flen(d) + 2; k++)
      tbl.push_back('{(k == pulse_k), (k == pulse_k) ? pulse_d : 4'h0, expv(f, d, k)});
  endtask

  task automatic run_table(int u, string tag);
    foreach (tbl[i]) begin
      drive(u, tbl[i].v, tbl[i].d);
      tick();
      check($sformatf("%s_k%0d", tag, i + 1), got(u), tbl[i].e);
    end
    drive(u, 1'b0, 4'h0);
  endtask

  initial begin
    logic [3:0] f;
    int per, k;

    rst_n = 1'b0;
    drive(0, 1'b0, 4'h0);
    drive(1, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", got(0), IDLE_RST);
    check("reset_b", got(1), IDLE_RST);
    rst_n = 1'b1;
    tick();
    check("post_reset_a", got(0), IDLE_RST);

    // Frame 1010 with a stray mid-scan request that must be ignored.
    build(DA, 4'b1010, 6, 4'b0101);
    run_table(0, "a1010");

    build(DB, 4'b1111, 0, 4'h0);
    run_table(1, "b1111");

    build(DB, 4'b0000, 0, 4'h0);
    run_table(1, "b0000");

    // iValid held high with alternating frames: second accepted in the oDone cycle.
    for (int fi = 0; fi < 2; fi++) begin
      f = (fi == 0) ? 4'b0001 : 4'b1000;
      drive(0, 1'b1, f);
      for (int kk = 1; kk <= flen(DA) + 1; kk++) begin
        tick();
        check($sformatf("b2b%0d_k%0d", fi, kk), got(0), expv(f, DA, kk));
      end
    end
    drive(0, 1'b0, 4'h0);
    tick();
    check("b2b_idle", got(0), expv(4'b1000, DA, flen(DA) + 2));

    // Asynchronous reset while channel 2 is being driven.
`ifdef SCAN_BLANK_EN
    per = DA + 1;
`else
    per = DA;
`endif
    drive(0, 1'b1, 4'b1111);
    tick();
    drive(0, 1'b0, 4'h0);
    k = 1;
    while (k < 2 * per + 1) begin
      tick();
      k++;
    end
    check("mid_ch2", got(0), expv(4'b1111, DA, k));
    #2 rst_n = 1'b0;
    #1 check("async_rst", got(0), IDLE_RST);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4 * per; i++) begin
      tick();
      check($sformatf("after_rst_%0d", i), got(0), IDLE_RST);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_driver14.md
Name: scan_driver14

Overview:
- Sequential front end for the 1-to-4 active-low demultiplexer stage.
- Accepts a 4-bit strobe frame over a valid/ready handshake, then scans channels 0..3 in order, holding each for DWELL clocks.
- Drives the demux data input and the two select inputs so that each channel whose frame bit is 1 is pulled low for its dwell window; all other channels stay high.
- Outputs connect directly to the demux iC/iS1/iS0 inputs.

Parameters:
- DWELL, 4, clocks each channel is held; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iData  input  4  strobe frame; bit k=1 means assert (drive low) channel k.
- iValid  input  1  iData valid.
- oReady  output  1  block can accept a frame this cycle.
- oC  output  1  demux data input; 1 = inactive, 0 = strobe.
- oS1  output  1  demux select MSB.
- oS0  output  1  demux select LSB.
- oBusy  output  1  a frame is being scanned.
- oDone  output  1  one-cycle pulse when a frame finishes.

Behaviour:
- Interface: one clock (iClk); reset iRst_n is asynchronous, active-low. All state is asynchronously cleared on iRst_n=0.
- Reset values: oC=1, oS1=0, oS0=0, oBusy=0, oDone=0, oReady=1.
- oC, oS1, oS0, oBusy and oDone are registered. oReady is decoded as (state==IDLE).
- States: IDLE, DRIVE, BLANK (BLANK exists only with the optional feature).

IDLE:
- oC=1, {oS1,oS0} hold their last value, oBusy=0.
- On iValid && oReady at edge t: latch iData into frame, set ch=0, clear the counter, go to DRIVE.
- The outputs for channel 0 are visible from cycle t+1, so accept-to-first-strobe latency is 1 clock.

DRIVE:
- Outputs: {oS1,oS0}=ch, oC=~frame[ch], oBusy=1.
- The counter counts 0..DWELL-1.
- At count DWELL-1 with ch<3: ch increments and the counter clears; go to BLANK if the feature is enabled, otherwise stay in DRIVE.
- At count DWELL-1 with ch==3: go to IDLE, and oDone=1 for exactly the next cycle (the first IDLE cycle, where oReady is also 1).

Timing and boundary rules:
- Frame length is 4*DWELL clocks without the feature, 4*DWELL+3 with it.
- Back-to-back frames: a new frame can be accepted in the same cycle oDone is high. That gives a minimum one-cycle idle gap (oC=1) between frames.
- iValid and iData are ignored while busy; there is no queuing, and the frame register is not disturbed.
- DWELL=1: each channel is driven for exactly one cycle, and select changes every cycle.
- frame=4'b0000: the full scan still runs with oC=1 throughout, and oDone still pulses.
- Reset mid-frame: return to IDLE immediately and discard the frame; no oDone is produced.
- Select wrap: ch is 2 bits and never advances past 3. The transition to IDLE replaces any wrap.

Optional Feature:
Macro SCAN_BLANK_EN.
- Defined: a one-cycle BLANK state is inserted between consecutive channels. In BLANK, oC=1 and select already shows the new ch, so the select change never coincides with an active-low strobe. There is no BLANK after channel 3 or before channel 0.
- Undefined: channels are adjacent; oC and select update on the same edge.

Decomposition:
- Package scan14_pkg contains:
  - state typedef {IDLE, DRIVE, BLANK};
  - localparam NUM_CH=4;
  - localparam C_INACTIVE=1'b1;
  - channel-index typedef logic [1:0].
- One natural sub-module, dwell_timer: a CNT_W counter with clear/enable and a terminal flag at DWELL-1. It is instantiated once.

Test Plan:
- Reset, then iData=4'b1010 with iValid for one cycle, DWELL=4 -> ch0 oC=1 for 4 clks; ch1 oC=0 for 4; ch2 oC=1 for 4; ch3 oC=0 for 4; oDone high on clock 17 after accept; oReady low during the scan.
- DWELL=1 with iData=4'b1111 -> select steps 00,01,10,11 on consecutive cycles with oC=0 each cycle; oDone follows one cycle later.
- Hold iValid high continuously with alternating frames 4'b0001/4'b1000 -> second frame accepted in the oDone cycle; exactly one oC=1 idle cycle between frames.
- Pulse iValid with new data mid-scan -> ignored; outputs follow the original frame, and a later frame is accepted only when oReady=1.
- Assert iRst_n=0 during ch2 of a frame -> oC=1, select=00, oBusy=0, oReady=1 immediately (asynchronous); no oDone after release.
- With SCAN_BLANK_EN, frame 4'b1111, DWELL=2 -> pattern per channel is 2 clks oC=0 then 1 clk oC=1; total 11 clks; select changes only on the BLANK cycles.
